serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 8, operand and result width in bits (legal range 2..64).
REQ-002 The port clk SHALL be: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The port rst_n SHALL be: input, 1 bit; reset is asynchronous and active-low.
REQ-004 The port start_valid SHALL be: input, 1 bit, operands valid.
REQ-005 The port start_ready SHALL be: output, 1 bit, block can accept operands.
REQ-006 The port a_in SHALL be: input, WIDTH bits, minuend (unsigned).
REQ-007 The port b_in SHALL be: input, WIDTH bits, subtrahend (unsigned).
REQ-008 The port res_valid SHALL be: output, 1 bit, result valid.
REQ-009 The port res_ready SHALL be: input, 1 bit, consumer accepts result.
REQ-010 The port diff SHALL be: output, WIDTH bits, (a_in - b_in) mod 2^WIDTH.
REQ-011 The port borrow_out SHALL be: output, 1 bit, set when a_in < b_in (unsigned).

Function
REQ-012 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-013 start_ready SHALL be 1 only in IDLE, and res_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, start_valid=1 SHALL accept the operands: capture a_in/b_in into shift registers, clear the borrow flop and bit counter, and go to BUSY.
REQ-015 a_in/b_in SHALL be sampled only on the accept edge; later changes SHALL have no effect on the result.
REQ-016 BUSY SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-017 Each BUSY cycle SHALL compute d = a^b^bin and bout = (~a&b) | (~(a^b)&bin), shift d into the result register MSB-first so that bit 0 lands at diff[0], and register bout as the next bin.
REQ-018 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL move to DONE on the cycle it processes bit WIDTH-1 (no counter wrap is observable).
REQ-019 Latency SHALL be exactly WIDTH cycles from the accept edge to the first cycle with res_valid=1.
REQ-020 In DONE, borrow_out SHALL equal the final bout, and diff and borrow_out SHALL be held stable until the handshake completes.
REQ-021 In DONE, res_ready=1 SHALL complete the handshake and return the FSM to IDLE the next cycle; start_ready SHALL rise in that cycle (no same-cycle result/accept bypass).
REQ-022 start_valid SHALL be ignored in BUSY and DONE, with no queueing and no corruption of the operation in progress.
REQ-023 res_ready SHALL be ignored outside DONE.
REQ-024 Wrap-around SHALL follow modular arithmetic: 0 - 1 SHALL give diff = all ones with borrow_out = 1, and x - x SHALL give 0 with borrow_out = 0.
REQ-025 diff and borrow_out SHALL retain their last values while in IDLE after a completed handshake.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, start_ready=1, res_valid=0, diff=0, borrow_out=0, and clear the operand, result, counter and borrow registers.
REQ-027 Reset asserted in BUSY or DONE SHALL abandon the operation with no partial result ever presented.
REQ-028 The first accept after reset release SHALL behave exactly as from power-up.

Structure
REQ-029 A shared package serial_arith_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the default WIDTH constant.
REQ-030 The module SHALL contain one sub-module, half_subtractor (inputs x, y; outputs d = x^y, b = ~x&y), instantiated twice, with the two borrows ORed to form the full-subtractor bit cell.
REQ-031 The whole block SHALL use one clock domain and no latches.

Verification (WIDTH=8)
REQ-032 The bench SHALL check: accept a=0x35, b=0x12 -> res_valid exactly 8 cycles after accept, diff=0x23, borrow_out=0.
REQ-033 The bench SHALL check: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xAA, b=0xAA -> diff=0x00, borrow_out=0.
REQ-034 The bench SHALL check backpressure: hold res_ready=0 for 5 cycles in DONE -> diff/borrow_out stable, start_ready=0, a start_valid pulse with new operands ignored; then res_ready=1 -> IDLE next cycle.
REQ-035 The bench SHALL check that changing a_in/b_in every BUSY cycle after accepting a=0x80, b=0x7F -> diff=0x01, borrow_out=0.
REQ-036 The bench SHALL check that asserting rst_n=0 on the 3rd BUSY cycle -> immediate res_valid=0, diff=0, start_ready=1, and a following op a=0x10, b=0x20 -> diff=0xF0, borrow_out=1.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks.
// Holds the controller state encoding and the default operand width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference and borrow of x - y.
// Two of these plus an OR make a full-subtractor cell.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    assign d = x ^ y;
    assign b = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Valid/ready handshakes on both the operand and the result side.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             borrow_d;
    logic             borrow_out_q;
    logic             start_ready_q;
    logic             res_valid_q;

    logic hsDiff;
    logic hsBorrowAB;
    logic hsBorrowIn;
    logic bitDiff;

    half_subtractor u_hs_ab (
        .x (a_q[0]),
        .y (b_q[0]),
        .d (hsDiff),
        .b (hsBorrowAB)
    );

    half_subtractor u_hs_bin (
        .x (hsDiff),
        .y (borrow_q),
        .d (bitDiff),
        .b (hsBorrowIn)
    );

    // New bits enter at the MSB so that after WIDTH shifts bit 0 sits at res[0].
    assign borrow_d = hsBorrowAB | hsBorrowIn;
    assign res_d    = {bitDiff, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            diff_q        <= '0;
            cnt_q         <= '0;
            borrow_q      <= 1'b0;
            borrow_out_q  <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q           <= a_in;
                        b_q           <= b_in;
                        res_q         <= '0;
                        cnt_q         <= '0;
                        borrow_q      <= 1'b0;
                        start_ready_q <= 1'b0;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // Visible outputs only change when the full result is known.
                    if (cnt_q == LAST_BIT) begin
                        diff_q       <= res_d;
                        borrow_out_q <= borrow_d;
                        res_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    res_valid_q   <= 1'b0;
                    start_ready_q <= 1'b1;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign diff        = diff_q;
    assign borrow_out  = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8: directed vector
// table, handshake/reset corner sequences and random ops against a model.
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expDiff;
        logic         expBorrow;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] diff;
    logic         borrow_out;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .diff        (diff),
        .borrow_out  (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts one operand pair and returns cycles from accept edge to res_valid.
    // With scramble set, operands and start_valid are churned while busy.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit scramble, output int lat);
        int waitCnt;
        lat = -1;
        @(negedge clk);
        waitCnt = 0;
        while (!start_ready && waitCnt < TIMEOUT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("start_ready_wait", 64'(start_ready), 64'd1);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            if (scramble) begin
                a_in        = W'($urandom);
                b_in        = W'($urandom);
                start_valid = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (res_valid) begin
                lat = c;
                break;
            end
        end
        start_valid = 1'b0;
    endtask

    task automatic finishHandshake();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("hs_res_valid_low", 64'(res_valid), 64'd0);
        checkOutput("hs_start_ready_high", 64'(start_ready), 64'd1);
    endtask

    task automatic runAndCheck(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expDiff, input logic expBorrow, input bit scramble);
        int lat;
        applyStimulus(a, b, scramble, lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(W));
        checkOutput({tag, "_diff"}, 64'(diff), 64'(expDiff));
        checkOutput({tag, "_borrow"}, 64'(borrow_out), 64'(expBorrow));
        finishHandshake();
        checkOutput({tag, "_diff_held_idle"}, 64'(diff), 64'(expDiff));
        checkOutput({tag, "_borrow_held_idle"}, 64'(borrow_out), 64'(expBorrow));
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   wide;

        vecs[0] = '{a: 8'h35, b: 8'h12, expDiff: 8'h23, expBorrow: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, expDiff: 8'hFF, expBorrow: 1'b1};
        vecs[2] = '{a: 8'hAA, b: 8'hAA, expDiff: 8'h00, expBorrow: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'h00, expDiff: 8'hFF, expBorrow: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'hFF, expDiff: 8'h01, expBorrow: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h80, expDiff: 8'hFF, expBorrow: 1'b1};
        vecs[6] = '{a: 8'hC3, b: 8'h5A, expDiff: 8'h69, expBorrow: 1'b0};
        vecs[7] = '{a: 8'h01, b: 8'h02, expDiff: 8'hFF, expBorrow: 1'b1};

        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a_in        = '0;
        b_in        = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_start_ready", 64'(start_ready), 64'd1);
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_diff", 64'(diff), 64'd0);
        checkOutput("reset_borrow", 64'(borrow_out), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                        vecs[i].expDiff, vecs[i].expBorrow, 1'b0);
        end

        // Operands churned every busy cycle must not leak into the result.
        runAndCheck("scramble", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);

        // Backpressure: result held, new request ignored, then released.
        applyStimulus(8'h5A, 8'h3C, 1'b0, lat);
        checkOutput("bp_latency", 64'(lat), 64'(W));
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start_valid = 1'b1;
                a_in        = 8'h01;
                b_in        = 8'h02;
            end else begin
                start_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_res_valid", 64'(res_valid), 64'd1);
            checkOutput("bp_diff", 64'(diff), 64'h1E);
            checkOutput("bp_borrow", 64'(borrow_out), 64'd0);
            checkOutput("bp_start_ready", 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        finishHandshake();
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_no_queued_op", 64'(start_ready), 64'd1);
        checkOutput("bp_diff_after", 64'(diff), 64'h1E);

        // Reset during the third busy cycle abandons the operation.
        @(negedge clk);
        start_valid = 1'b1;
        a_in        = 8'hFF;
        b_in        = 8'h01;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_busy_diff", 64'(diff), 64'd0);
        checkOutput("rst_busy_start_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        runAndCheck("post_reset", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);

        // Random operands against a plain wide-subtraction model.
        for (int i = 0; i < 24; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            wide = {1'b0, ra} - {1'b0, rb};
            runAndCheck($sformatf("rand%0d", i), ra, rb, wide[W-1:0], wide[W], 1'(i % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
